sram_march_ctrl: RTL

- Self-test sequencer for one OpenRAM single-port SRAM macro on the test chip.
- Runs a March C- style sequence against the macro port: write, read, compare, reverse-order sweeps.
- Reports done, pass/fail, first-failure location and error count for the LA/GPIO status pins.
- Sits between the mode-select mux and the SRAM port, in place of the scan-chain driver, when self-test mode is selected.

---
 rtl/sram_march_ctrl_if.sv | 24 ++
 rtl/sram_march_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sram_march_ctrl_if.sv
// SRAM macro port bundle between the march controller and one OpenRAM
// single-port macro.
//   csb   : chip select, active low
//   web   : write enable, active low
//   wmask : byte/segment write mask
//   addr  : word address
//   din   : write data
//   dout  : read data from the macro
// master = controller side, slave = macro side.
interface sram_march_ctrl_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
);
  logic                   csb;
  logic                   web;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;

  modport master (output csb, web, wmask, addr, din, input dout);
  modport slave  (input csb, web, wmask, addr, din, output dout);
endinterface

// File: rtl/sram_march_ctrl.sv
// March C- self-test sequencer for one single-port SRAM macro.
// Elements: E0 up W0 | E1 up R0,W1 | E2 up R1,W0 | E3 down R0,W1 |
//           E4 down R1,W0 | E5 up R0.  "0" = latched bg, "1" = ~bg.
// Ports:
//   clk, resetn    : clock, async active-low reset
//   start          : begin a run (accepted in IDLE or DONE only)
//   bg_pattern     : background word, latched on accepted start
//   stop_on_fail   : abort on first mismatch, latched on accepted start
//   sram           : macro port (master side)
//   busy, done     : run in progress / run finished or aborted (sticky)
//   fail           : any mismatch in this run (sticky)
//   fail_addr/elem : location of the first mismatch
//   err_count      : mismatching reads, saturating at 255
module sram_march_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bg_pattern,
  input  logic                  stop_on_fail,
  sram_march_ctrl_if.master     sram,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [7:0]            err_count
);
  localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, DONE} state_t;

  state_t                st, st_n;
  logic [2:0]            elem, elem_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [WCW-1:0]        wcnt, wcnt_n;
  logic [DATA_WIDTH-1:0] bg, bg_n, din, din_n;
  logic                  sof, sof_n;
  logic                  fail_n;
  logic [ADDR_WIDTH-1:0] fail_addr_n;
  logic [2:0]            fail_elem_n;
  logic [7:0]            err_count_n;

  // Element decode: E3/E4 run downwards, E2/E4 read the inverted pattern,
  // E1/E3 write the inverted pattern.
  logic [2:0] elem_inc;
  logic       desc, desc_nxt, last_addr, rd_last, miss;
  logic [DATA_WIDTH-1:0] rd_exp, wr_val;

  assign elem_inc  = 3'(elem + 3'd1);
  assign desc      = (elem == 3'd3) || (elem == 3'd4);
  assign desc_nxt  = (elem_inc == 3'd3) || (elem_inc == 3'd4);
  assign last_addr = desc ? (addr == '0) : (addr == '1);
  assign rd_exp    = ((elem == 3'd2) || (elem == 3'd4)) ? ~bg : bg;
  assign wr_val    = ((elem == 3'd1) || (elem == 3'd3)) ? ~bg : bg;
  assign rd_last   = (st == RD_WAIT) && (wcnt == WCW'(READ_LATENCY - 1));
  assign miss      = rd_last && (sram.dout != rd_exp);

  always_comb begin
    st_n        = st;
    elem_n      = elem;
    addr_n      = addr;
    wcnt_n      = wcnt;
    bg_n        = bg;
    din_n       = din;
    sof_n       = sof;
    fail_n      = fail;
    fail_addr_n = fail_addr;
    fail_elem_n = fail_elem;
    err_count_n = err_count;

    if (miss) begin
      fail_n = 1'b1;
      if (err_count != 8'hff) err_count_n = err_count + 8'd1;
      if (!fail) begin
        fail_addr_n = addr;
        fail_elem_n = elem;
      end
    end

    case (st)
      IDLE, DONE: begin
        if (start) begin
          st_n        = WR;
          elem_n      = 3'd0;
          addr_n      = '0;
          din_n       = bg_pattern;
          bg_n        = bg_pattern;
          sof_n       = stop_on_fail;
          fail_n      = 1'b0;
          fail_addr_n = '0;
          fail_elem_n = 3'd0;
          err_count_n = 8'd0;
        end
      end
      // A write is always the last op at its address, so it also decides
      // the next address / element with no bubble.
      WR: begin
        st_n = RD_ISSUE;
        if (last_addr) begin
          elem_n = elem_inc;
          addr_n = desc_nxt ? '1 : '0;
        end else begin
          addr_n = desc ? addr - 1'b1 : addr + 1'b1;
          if (elem == 3'd0) st_n = WR;
        end
      end
      RD_ISSUE: begin
        st_n   = RD_WAIT;
        wcnt_n = '0;
      end
      RD_WAIT: begin
        if (!rd_last) begin
          wcnt_n = wcnt + 1'b1;
        end else if (miss && sof) begin
          st_n = DONE;
        end else if (elem == 3'd5) begin
          if (last_addr) st_n = DONE;
          else begin
            addr_n = addr + 1'b1;
            st_n   = RD_ISSUE;
          end
        end else begin
          st_n  = WR;
          din_n = wr_val;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= IDLE;
      elem      <= 3'd0;
      addr      <= '0;
      wcnt      <= '0;
      bg        <= '0;
      din       <= '0;
      sof       <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      err_count <= 8'd0;
    end else begin
      st        <= st_n;
      elem      <= elem_n;
      addr      <= addr_n;
      wcnt      <= wcnt_n;
      bg        <= bg_n;
      din       <= din_n;
      sof       <= sof_n;
      fail      <= fail_n;
      fail_addr <= fail_addr_n;
      fail_elem <= fail_elem_n;
      err_count <= err_count_n;
    end
  end

  // addr/din are registers, so they hold while csb is high.
  assign sram.csb   = !((st == WR) || (st == RD_ISSUE));
  assign sram.web   = (st != WR);
  assign sram.wmask = (st == WR) ? '1 : '0;
  assign sram.addr  = addr;
  assign sram.din   = din;
  assign busy       = (st == WR) || (st == RD_ISSUE) || (st == RD_WAIT);
  assign done       = (st == DONE);
endmodule
